// File: rtl/dcache_direct_wb_if.sv
// rtl/dcache_direct_wb_if.sv - CPU byte port and backing-memory block port bundle for dcache_direct_wb
interface dcache_direct_wb_if;
    logic        read;
    logic        write;
    logic [7:0]  address;
    logic [7:0]  writedata;
    logic [7:0]  readdata;
    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    // Cache side: serves the CPU, drives block requests to memory
    modport slave (
        input  read, write, address, writedata, mem_readdata, mem_busywait,
        output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
    );

    // Environment side: CPU plus backing memory
    modport master (
        output read, write, address, writedata, mem_readdata, mem_busywait,
        input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
    );
endinterface

// File: rtl/dcache_direct_wb.sv
// rtl/dcache_direct_wb.sv - direct-mapped write-back write-allocate data cache, 8 blocks x 4 bytes
module dcache_direct_wb (
    input  logic              clock,
    input  logic              reset,
    dcache_direct_wb_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_BACK = 2'd1,
        FETCH      = 2'd2,
        UPDATE     = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] data_q  [8];
    logic [2:0]  tag_q   [8];
    logic [7:0]  valid_q;
    logic [7:0]  dirty_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [5:0]  mem_address_q;
    logic [31:0] mem_writedata_q;
    logic [7:0]  readdata_q;
    logic [7:0]  readdata_d;

    logic [2:0]  tag_in;
    logic [2:0]  index;
    logic [1:0]  offset;
    logic [4:0]  bit_pos;
    logic        access;
    logic        hit;
    logic [7:0]  sel_byte;

    assign tag_in  = bus.address[7:5];
    assign index   = bus.address[4:2];
    assign offset  = bus.address[1:0];
    assign bit_pos = {offset, 3'b000};

    // read together with write is treated as no request at all
    assign access   = bus.read ^ bus.write;
    assign hit      = valid_q[index] && (tag_q[index] == tag_in);
    assign sel_byte = data_q[index][bit_pos +: 8];

    // Stall on a miss or while a refill is in progress; reset forces it low
    assign bus.busywait = reset && ((access && !hit) || (state_q != IDLE));

    // Read hits are visible in the same cycle; otherwise the last byte is held
    always_comb begin
        readdata_d = readdata_q;
        if (access && bus.read && hit) begin
            readdata_d = sel_byte;
        end
    end

    assign bus.readdata      = readdata_d;
    assign bus.mem_read      = mem_read_q;
    assign bus.mem_write     = mem_write_q;
    assign bus.mem_address   = mem_address_q;
    assign bus.mem_writedata = mem_writedata_q;

    // Miss FSM, block arrays and registered memory-side outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            valid_q         <= '0;
            dirty_q         <= '0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
            readdata_q      <= '0;
            for (int i = 0; i < 8; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            readdata_q <= readdata_d;
            case (state_q)
                IDLE: begin
                    if (access && hit && bus.write) begin
                        data_q[index][bit_pos +: 8] <= bus.writedata;
                        dirty_q[index]              <= 1'b1;
                    end else if (access && !hit) begin
                        if (dirty_q[index]) begin
                            // victim goes out first, addressed by its own stored tag
                            state_q         <= WRITE_BACK;
                            mem_write_q     <= 1'b1;
                            mem_address_q   <= {tag_q[index], index};
                            mem_writedata_q <= data_q[index];
                        end else begin
                            state_q       <= FETCH;
                            mem_read_q    <= 1'b1;
                            mem_address_q <= {tag_in, index};
                        end
                    end
                end
                WRITE_BACK: begin
                    if (!bus.mem_busywait) begin
                        state_q       <= FETCH;
                        mem_write_q   <= 1'b0;
                        mem_read_q    <= 1'b1;
                        mem_address_q <= {tag_in, index};
                    end
                end
                FETCH: begin
                    if (!bus.mem_busywait) begin
                        state_q    <= UPDATE;
                        mem_read_q <= 1'b0;
                    end
                end
                UPDATE: begin
                    // memory keeps the fetched block on mem_readdata through this cycle
                    data_q[index]  <= bus.mem_readdata;
                    tag_q[index]   <= tag_in;
                    valid_q[index] <= 1'b1;
                    dirty_q[index] <= 1'b0;
                    state_q        <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_direct_wb.sv
// tb/tb_dcache_direct_wb.sv - directed table and miss-sequence bench for dcache_direct_wb
module tb_dcache_direct_wb;
    localparam int LAT = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;

    dcache_direct_wb_if bus ();

    dcache_direct_wb dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Backing memory: fixed latency, busywait rises with the request, data held after completion
    logic [31:0] mem_arr [64];
    bit          mem_wr  [64];
    logic [31:0] mem_rdata = '0;
    logic        mem_ready;
    int          mem_cnt;

    function automatic logic [31:0] mem_default(input logic [5:0] a);
        case (a)
            6'h00:   return 32'h44332211;
            6'h08:   return 32'hDDCCBBAA;
            6'h11:   return 32'h87654321;
            default: return 32'hA0B0C000 | {26'd0, a};
        endcase
    endfunction

    function automatic logic [31:0] mem_peek(input logic [5:0] a);
        return mem_wr[a] ? mem_arr[a] : mem_default(a);
    endfunction

    assign bus.mem_busywait = (bus.mem_read | bus.mem_write) & ~mem_ready;
    assign bus.mem_readdata = mem_rdata;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_ready <= 1'b0;
            mem_cnt   <= 0;
        end else if (bus.mem_read || bus.mem_write) begin
            if (mem_ready) begin
                mem_ready <= 1'b0;
                mem_cnt   <= 0;
            end else if (mem_cnt == LAT - 1) begin
                mem_ready <= 1'b1;
                mem_cnt   <= 0;
                if (bus.mem_write) begin
                    mem_arr[bus.mem_address] <= bus.mem_writedata;
                    mem_wr[bus.mem_address]  <= 1'b1;
                end else begin
                    mem_rdata <= mem_peek(bus.mem_address);
                end
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end else begin
            mem_ready <= 1'b0;
            mem_cnt   <= 0;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic monitor_miss(output int cyc, output bit saw_wb, output logic [5:0] wb_a,
                                output logic [31:0] wb_d, output bit saw_f, output logic [5:0] f_a,
                                output bit both, output bit tmo);
        cyc = 0; saw_wb = 0; wb_a = '0; wb_d = '0; saw_f = 0; f_a = '0; both = 0; tmo = 0;
        #1;
        while (bus.busywait === 1'b1) begin
            if (bus.mem_read && bus.mem_write) both = 1;
            if (bus.mem_write && !saw_wb) begin
                saw_wb = 1; wb_a = bus.mem_address; wb_d = bus.mem_writedata;
            end
            if (bus.mem_read && !saw_f) begin
                saw_f = 1; f_a = bus.mem_address;
            end
            cyc++;
            if (cyc >= 60) begin
                tmo = 1;
                break;
            end
            @(negedge clock);
            #1;
        end
    endtask

    // Request already applied; follow it until busywait drops and check what the memory saw
    task automatic check_miss(input string nm, input bit exp_wb, input logic [5:0] ewa,
                              input logic [31:0] ewd, input logic [5:0] efa, input int ecyc,
                              input bit chk_rd, input logic [7:0] erd);
        int          cyc;
        bit          saw_wb, saw_f, both, tmo;
        logic [5:0]  wb_a, f_a;
        logic [31:0] wb_d;
        monitor_miss(cyc, saw_wb, wb_a, wb_d, saw_f, f_a, both, tmo);
        check({nm, " timeout"}, {31'd0, tmo}, 32'd0);
        check({nm, " writeback seen"}, {31'd0, saw_wb}, {31'd0, exp_wb});
        if (exp_wb) begin
            check({nm, " wb address"}, {26'd0, wb_a}, {26'd0, ewa});
            check({nm, " wb data"}, wb_d, ewd);
        end
        check({nm, " fetch seen"}, {31'd0, saw_f}, 32'd1);
        check({nm, " fetch address"}, {26'd0, f_a}, {26'd0, efa});
        check({nm, " rd and wr together"}, {31'd0, both}, 32'd0);
        check({nm, " stall cycles"}, cyc, ecyc);
        check({nm, " mem idle after"}, {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        if (chk_rd) check({nm, " readdata"}, {24'd0, bus.readdata}, {24'd0, erd});
    endtask

    typedef struct {
        bit         rd;
        bit         wr;
        logic [7:0] a;
        logic [7:0] wd;
        logic [7:0] exp_rd;
        string      nm;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{1'b0, 1'b1, 8'h01, 8'hAB, 8'h33, "write hit 01"};
        vecs[1] = '{1'b1, 1'b0, 8'h01, 8'h00, 8'hAB, "read hit 01"};
        vecs[2] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h11, "read hit 00"};
        vecs[3] = '{1'b1, 1'b0, 8'h02, 8'h00, 8'h33, "read hit 02"};
        vecs[4] = '{1'b1, 1'b0, 8'h03, 8'h00, 8'h44, "read hit 03"};
        vecs[5] = '{1'b1, 1'b1, 8'h00, 8'hFF, 8'h44, "rd+wr ignored"};
        vecs[6] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h11, "byte 00 unchanged"};

        bus.read = 1'b0; bus.write = 1'b0; bus.address = '0; bus.writedata = '0;

        // reset state
        reset = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("reset busywait", {31'd0, bus.busywait}, 32'd0);
        check("reset mem_read/write", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        check("reset mem_address", {26'd0, bus.mem_address}, 32'd0);
        check("reset mem_writedata", bus.mem_writedata, 32'd0);
        check("reset readdata", {24'd0, bus.readdata}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // cold read miss
        @(negedge clock);
        bus.read = 1'b1; bus.address = 8'h02;
        check_miss("cold read 02", 1'b0, 6'h00, 32'h0, 6'h00, 6, 1'b1, 8'h33);

        // hits and the ignored read+write request
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            bus.read = vecs[i].rd; bus.write = vecs[i].wr;
            bus.address = vecs[i].a; bus.writedata = vecs[i].wd;
            #1;
            check({vecs[i].nm, " busywait"}, {31'd0, bus.busywait}, 32'd0);
            check({vecs[i].nm, " mem idle"}, {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
            check({vecs[i].nm, " readdata"}, {24'd0, bus.readdata}, {24'd0, vecs[i].exp_rd});
        end

        // dirty conflict miss on index 0
        @(negedge clock);
        bus.read = 1'b1; bus.write = 1'b0; bus.address = 8'h21;
        check_miss("dirty read 21", 1'b1, 6'h00, 32'h4433AB11, 6'h08, 10, 1'b1, 8'hBB);
        check("backing block 00", mem_peek(6'h00), 32'h4433AB11);

        // block 0 was installed clean, so returning to tag 0 needs no write-back
        @(negedge clock);
        bus.address = 8'h01;
        check_miss("clean read 01", 1'b0, 6'h00, 32'h0, 6'h00, 6, 1'b1, 8'hAB);

        // clean write miss, write allocated then completed
        @(negedge clock);
        bus.read = 1'b0; bus.write = 1'b1; bus.address = 8'h45; bus.writedata = 8'h5C;
        check_miss("write miss 45", 1'b0, 6'h00, 32'h0, 6'h11, 6, 1'b0, 8'h00);
        @(negedge clock);
        bus.read = 1'b1; bus.write = 1'b0; bus.address = 8'h45;
        #1;
        check("read 45 busywait", {31'd0, bus.busywait}, 32'd0);
        check("read 45 readdata", {24'd0, bus.readdata}, 32'h5C);

        // conflict on index 1 must write back the merged dirty block
        @(negedge clock);
        bus.address = 8'h65;
        check_miss("dirty read 65", 1'b1, 6'h11, 32'h87655C21, 6'h19, 10, 1'b1, 8'hC0);

        // reset two cycles into a fetch
        @(negedge clock);
        bus.address = 8'h0C;
        repeat (3) @(posedge clock);
        #1;
        check("fetch before reset", {31'd0, bus.mem_read}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("reset mid-fetch mem_read", {31'd0, bus.mem_read}, 32'd0);
        check("reset mid-fetch busywait", {31'd0, bus.busywait}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        check_miss("re-read 0C", 1'b0, 6'h00, 32'h0, 6'h03, 6, 1'b1, 8'h03);

        @(negedge clock);
        bus.read = 1'b0; bus.write = 1'b0;
        @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1);
    end
endmodule
